// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and the data path.
// Data wins arbitration, but a bounded streak guarantees fetch progress.
module mem_arbiter #(
    parameter int WORD_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ready
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I} state_t;

    state_t              state;
    logic [STREAK_W-1:0] dStreak;

    logic dReq;
    logic iStarved;
    logic dActive;
    logic iActive;

    assign dReq     = dREN | dWEN;
    assign iStarved = iREN && (dStreak == STREAK_MAX);

    // Gating with nRST makes a reset mid-transaction drop the access immediately.
    assign dActive = nRST && (state == SERVE_D) && dReq;
    assign iActive = nRST && (state == SERVE_I) && iREN;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            dStreak <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dReq && !iStarved) begin
                        state <= SERVE_D;
                    end else if (iREN) begin
                        state <= SERVE_I;
                    end
                end
                SERVE_D: begin
                    if (!dReq) begin
                        state <= IDLE;
                    end else if (ram_ready) begin
                        state <= IDLE;
                        if (!iREN) begin
                            dStreak <= '0;
                        end else if (dStreak != STREAK_MAX) begin
                            dStreak <= dStreak + STREAK_W'(1);
                        end
                    end
                end
                SERVE_I: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (ram_ready) begin
                        state   <= IDLE;
                        dStreak <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state so a wait releases in the very cycle the RAM is ready.
    assign ramREN   = (dActive && !dWEN) || iActive;
    assign ramWEN   = dActive && dWEN;
    assign ramaddr  = dActive ? daddr : (iActive ? iaddr : '0);
    assign ramstore = (dActive && dWEN) ? dstore : '0;
    assign dload    = dActive ? ramload : '0;
    assign iload    = iActive ? ramload : '0;
    assign dwait    = dReq && !(dActive && ram_ready);
    assign iwait    = iREN && !(iActive && ram_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Vector-table bench for mem_arbiter: each record is one clock cycle of inputs
// plus the grant and wait values expected during that cycle.
module tb_mem_arbiter;

    localparam int          WORD_W = 32;
    localparam logic [31:0] IADDR  = 32'h0000_0040;
    localparam logic [31:0] DADDR  = 32'h0000_0100;
    localparam logic [31:0] DSTORE = 32'hDEAD_BEEF;
    localparam logic [31:0] RLOAD  = 32'h8C22_0004;
    localparam int          G_NONE = 0;
    localparam int          G_D    = 1;
    localparam int          G_I    = 2;

    typedef struct {
        string tag;
        logic  rst;
        logic  iReq;
        logic  dRd;
        logic  dWr;
        logic  rdy;
        int    grant;
        logic  expIwait;
        logic  expDwait;
    } vec_t;

    typedef struct {
        string       tag;
        logic        ramREN;
        logic        ramWEN;
        logic [31:0] ramaddr;
        logic [31:0] ramstore;
        logic        chkStore;
        logic [31:0] iload;
        logic [31:0] dload;
        logic        iwait;
        logic        dwait;
    } exp_t;

    logic              CLK;
    logic              nRST;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic              ram_ready;

    vec_t vecs[$];
    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    mem_arbiter #(.WORD_W(WORD_W), .MAX_D_STREAK(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mkVec(string tag, logic rst, logic iReq, logic dRd, logic dWr,
                                   logic rdy, int grant, logic expIwait, logic expDwait);
        vec_t v;
        v.tag      = tag;
        v.rst      = rst;
        v.iReq     = iReq;
        v.dRd      = dRd;
        v.dWr      = dWr;
        v.rdy      = rdy;
        v.grant    = grant;
        v.expIwait = expIwait;
        v.expDwait = expDwait;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        nRST      = v.rst;
        iREN      = v.iReq;
        dREN      = v.dRd;
        dWEN      = v.dWr;
        ram_ready = v.rdy;
        e.tag      = v.tag;
        e.ramREN   = (v.grant == G_I) || (v.grant == G_D && !v.dWr);
        e.ramWEN   = (v.grant == G_D) && v.dWr;
        e.ramaddr  = (v.grant == G_D) ? DADDR : ((v.grant == G_I) ? IADDR : 32'h0);
        e.ramstore = e.ramWEN ? DSTORE : 32'h0;
        e.chkStore = !((v.grant == G_D) && !v.dWr);
        e.iload    = (v.grant == G_I) ? RLOAD : 32'h0;
        e.dload    = (v.grant == G_D) ? RLOAD : 32'h0;
        e.iwait    = v.expIwait;
        e.dwait    = v.expDwait;
        expQ.push_back(e);
    endtask

    task automatic compare(input string tag, input string name,
                           input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s %s: got %h expected %h at %0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = expQ.pop_front();
        compare(e.tag, "ramREN", 32'(ramREN), 32'(e.ramREN));
        compare(e.tag, "ramWEN", 32'(ramWEN), 32'(e.ramWEN));
        compare(e.tag, "ramaddr", ramaddr, e.ramaddr);
        if (e.chkStore) compare(e.tag, "ramstore", ramstore, e.ramstore);
        compare(e.tag, "iload", iload, e.iload);
        compare(e.tag, "dload", dload, e.dload);
        compare(e.tag, "iwait", 32'(iwait), 32'(e.iwait));
        compare(e.tag, "dwait", 32'(dwait), 32'(e.dwait));
    endtask

    initial begin
        nRST      = 1'b0;
        iREN      = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        ram_ready = 1'b0;
        iaddr     = IADDR;
        daddr     = DADDR;
        dstore    = DSTORE;
        ramload   = RLOAD;

        // Reset with both requests up, then data must be granted first.
        vecs.push_back(mkVec("reset0",   0, 1, 1, 0, 0, G_NONE, 1, 1));
        vecs.push_back(mkVec("reset1",   0, 1, 1, 0, 0, G_NONE, 1, 1));
        vecs.push_back(mkVec("postRst",  1, 1, 1, 0, 0, G_NONE, 1, 1));
        vecs.push_back(mkVec("firstD",   1, 1, 1, 0, 1, G_D,    1, 0));
        vecs.push_back(mkVec("idleI",    1, 1, 0, 0, 0, G_NONE, 1, 0));
        vecs.push_back(mkVec("serveI",   1, 1, 0, 0, 1, G_I,    0, 0));
        vecs.push_back(mkVec("quiet0",   1, 0, 0, 0, 0, G_NONE, 0, 0));
        // Single instruction read.
        vecs.push_back(mkVec("rdCyc1",   1, 1, 0, 0, 0, G_NONE, 1, 0));
        vecs.push_back(mkVec("rdCyc2",   1, 1, 0, 0, 1, G_I,    0, 0));
        vecs.push_back(mkVec("rdCyc3",   1, 0, 0, 0, 0, G_NONE, 0, 0));
        // Write beats a simultaneous fetch; write wins over read; ready ignored in idle.
        vecs.push_back(mkVec("wrIdle",   1, 1, 0, 1, 0, G_NONE, 1, 1));
        vecs.push_back(mkVec("wrBoth",   1, 1, 1, 1, 0, G_D,    1, 1));
        vecs.push_back(mkVec("wrDone",   1, 1, 0, 1, 1, G_D,    1, 0));
        vecs.push_back(mkVec("wrRdyIgn", 1, 1, 0, 0, 1, G_NONE, 1, 0));
        vecs.push_back(mkVec("wrThenI",  1, 1, 0, 0, 1, G_I,    0, 0));
        vecs.push_back(mkVec("quiet1",   1, 0, 0, 0, 0, G_NONE, 0, 0));
        // Starvation bound: D,D,D,D,I twice, so the streak restarts after each fetch.
        for (int k = 0; k < 10; k++) begin
            vecs.push_back(mkVec($sformatf("stvIdle%0d", k), 1, 1, 1, 0, 1, G_NONE, 1, 1));
            if ((k % 5) < 4) begin
                vecs.push_back(mkVec($sformatf("stvD%0d", k), 1, 1, 1, 0, 1, G_D, 1, 0));
            end else begin
                vecs.push_back(mkVec($sformatf("stvI%0d", k), 1, 1, 1, 0, 1, G_I, 0, 1));
            end
        end
        vecs.push_back(mkVec("quiet2",   1, 0, 0, 0, 0, G_NONE, 0, 0));
        // Data request withdrawn mid-service, pending fetch served afterwards.
        vecs.push_back(mkVec("abIdle",   1, 1, 1, 0, 0, G_NONE, 1, 1));
        vecs.push_back(mkVec("abServe",  1, 1, 1, 0, 0, G_D,    1, 1));
        vecs.push_back(mkVec("abDrop",   1, 1, 0, 0, 0, G_NONE, 1, 0));
        vecs.push_back(mkVec("abIdle2",  1, 1, 0, 0, 0, G_NONE, 1, 0));
        vecs.push_back(mkVec("abServeI", 1, 1, 0, 0, 1, G_I,    0, 0));
        vecs.push_back(mkVec("quiet3",   1, 0, 0, 0, 0, G_NONE, 0, 0));
        // Fetch withdrawn mid-service.
        vecs.push_back(mkVec("iaIdle",   1, 1, 0, 0, 0, G_NONE, 1, 0));
        vecs.push_back(mkVec("iaDrop",   1, 0, 0, 0, 1, G_NONE, 0, 0));
        vecs.push_back(mkVec("iaAfter",  1, 0, 0, 0, 1, G_NONE, 0, 0));
        // Reset during instruction service drops the access.
        vecs.push_back(mkVec("mrIdle",   1, 1, 0, 0, 0, G_NONE, 1, 0));
        vecs.push_back(mkVec("mrServe",  1, 1, 0, 0, 0, G_I,    1, 0));
        vecs.push_back(mkVec("mrReset",  0, 1, 0, 0, 1, G_NONE, 1, 0));
        vecs.push_back(mkVec("mrIdle2",  1, 1, 0, 0, 0, G_NONE, 1, 0));
        vecs.push_back(mkVec("mrRetry",  1, 1, 0, 0, 1, G_I,    0, 0));
        vecs.push_back(mkVec("quiet4",   1, 0, 0, 0, 0, G_NONE, 0, 0));

        foreach (vecs[n]) begin
            @(posedge CLK);
            #1;
            applyStimulus(vecs[n]);
            @(negedge CLK);
            checkOutput();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
